// File: rtl/hex_entry_ctrl.sv
// Four-digit hex entry controller for the 7-segment bank.
// Two debounced keys (enter, clear) fill the four display positions left to right, with a blinking cursor.
module hex_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] SW,
    input  logic       KEY_ENTER,
    input  logic       KEY_CLEAR,
    output logic [0:6] HEX3,
    output logic [0:6] HEX2,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0,
    output logic [1:0] ptr,
    output logic       full
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [0:6]    BLANK      = 7'b1111111;
    localparam logic [0:6]    CURSOR     = 7'b1110111;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL
    } state_t;

    logic [1:0]         keys;
    logic [1:0]         sync1_q;
    logic [1:0]         sync2_q;
    logic [1:0]         deb_q;
    logic [1:0]         press_q;
    logic [1:0][DW-1:0] debCnt_q;

    logic               enterEvt;
    logic               clearEvt;

    state_t             state_q, state_d;
    logic [3:0][3:0]    digit_q, digit_d;
    logic [3:0]         valid_q, valid_d;
    logic [1:0]         ptr_q, ptr_d;
    logic               full_q, full_d;

    logic [BW-1:0]      blinkCnt_q;
    logic               phase_q;

    logic [3:0][0:6]    hex_q, hex_d;

    function automatic logic [0:6] seg7(input logic [3:0] v);
        logic [0:6] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001101;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign keys = {KEY_CLEAR, KEY_ENTER};

    // Bit 0 is the enter key, bit 1 the clear key; press_q pulses for one cycle on a debounced fall.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            deb_q    <= '1;
            press_q  <= '0;
            debCnt_q <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == deb_q[i]) begin
                    debCnt_q[i] <= '0;
                end else if (debCnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= sync2_q[i];
                    debCnt_q[i] <= '0;
                    press_q[i]  <= ~sync2_q[i];
                end else begin
                    debCnt_q[i] <= debCnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign enterEvt = press_q[0];
    assign clearEvt = press_q[1];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            digit_q <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
        end
    end

    // Clear outranks a simultaneous enter.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        full_d  = full_q;
        if (clearEvt) begin
            state_d = EMPTY;
            digit_d = '0;
            valid_d = '0;
            ptr_d   = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                EMPTY, ENTRY: begin
                    if (enterEvt) begin
                        digit_d[ptr_q] = SW;
                        valid_d[ptr_q] = 1'b1;
                        if (ptr_q == 2'd3) begin
                            full_d  = 1'b1;
                            state_d = FULL;
                        end else begin
                            ptr_d   = ptr_q + 2'd1;
                            state_d = ENTRY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            blinkCnt_q <= '0;
            phase_q    <= 1'b1;
        end else if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_q <= '0;
            phase_q    <= ~phase_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + BW'(1);
        end
    end

    // Position p is shown on HEX(3-p); the cursor only appears on an empty slot before the bank is full.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            hex_d[p] = BLANK;
            if (valid_q[p]) begin
                hex_d[p] = seg7(digit_q[p]);
            end else if (ptr_q == 2'(p) && state_q != FULL) begin
                hex_d[p] = phase_q ? CURSOR : BLANK;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hex_q <= {4{BLANK}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign HEX3 = hex_q[0];
    assign HEX2 = hex_q[1];
    assign HEX1 = hex_q[2];
    assign HEX0 = hex_q[3];
    assign ptr  = ptr_q;
    assign full = full_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Randomized bench for hex_entry_ctrl: a sliding-window key model plus a digit-bank model predicts every output each cycle.
module tb_hex_entry_ctrl;

    localparam int DB = 4;
    localparam int BD = 8;

    logic       clock;
    logic       resetn;
    logic [3:0] sw;
    logic       keyEnter;
    logic       keyClear;
    logic [0:6] hex3, hex2, hex1, hex0;
    logic [1:0] ptr;
    logic       full;

    int compared;
    int mismatched;

    logic [0:6] segTable [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    hex_entry_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .BLINK_DIV(BD)
    ) dut (
        .CLOCK_50(clock),
        .resetn(resetn),
        .SW(sw),
        .KEY_ENTER(keyEnter),
        .KEY_CLEAR(keyClear),
        .HEX3(hex3),
        .HEX2(hex2),
        .HEX1(hex1),
        .HEX0(hex0),
        .ptr(ptr),
        .full(full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: digit bank as arrays, blink phase from the edge count, keys as a window of raw samples.
    logic [3:0] mDigit [4];
    bit         mValid [4];
    int         mPtr;
    bit         mFull;
    int         mCyc;
    bit [1:0]   mEv;
    bit [1:0]   mDeb;
    bit         histEnter [$];
    bit         histClear [$];
    logic [0:6] expHex [4];
    bit         mPhase;
    bit         flipE;
    bit         flipC;

    function automatic logic [0:6] displayOf(input int p, input bit phase);
        if (mValid[p]) return segTable[mDigit[p]];
        if (p == mPtr && !mFull) return phase ? 7'b1110111 : 7'b1111111;
        return 7'b1111111;
    endfunction

    // A debounced level flips once the D samples taken before the two synchronizer stages all disagree with it.
    function automatic bit windowFlips(input bit q[$], input bit level);
        for (int i = 0; i < DB; i++) begin
            if (q[i] == level) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < 4; p++) begin
                mDigit[p] = 4'h0;
                mValid[p] = 1'b0;
                expHex[p] = 7'b1111111;
            end
            mPtr = 0;
            mFull = 1'b0;
            mCyc = 0;
            mEv = 2'b00;
            mDeb = 2'b11;
            histEnter.delete();
            histClear.delete();
            for (int i = 0; i < DB + 2; i++) begin
                histEnter.push_back(1'b1);
                histClear.push_back(1'b1);
            end
        end else begin
            mPhase = ((mCyc / BD) % 2) == 0;
            for (int p = 0; p < 4; p++) expHex[p] = displayOf(p, mPhase);
            if (mEv[1]) begin
                for (int p = 0; p < 4; p++) begin
                    mDigit[p] = 4'h0;
                    mValid[p] = 1'b0;
                end
                mPtr = 0;
                mFull = 1'b0;
            end else if (mEv[0] && !mFull) begin
                mDigit[mPtr] = sw;
                mValid[mPtr] = 1'b1;
                if (mPtr == 3) mFull = 1'b1;
                else mPtr++;
            end
            mCyc++;
            histEnter.push_back(keyEnter);
            void'(histEnter.pop_front());
            histClear.push_back(keyClear);
            void'(histClear.pop_front());
            flipE = windowFlips(histEnter, mDeb[0]);
            flipC = windowFlips(histClear, mDeb[1]);
            if (flipE) mDeb[0] = ~mDeb[0];
            if (flipC) mDeb[1] = ~mDeb[1];
            mEv[0] = flipE && !mDeb[0];
            mEv[1] = flipC && !mDeb[1];
        end
    end

    always @(negedge clock) begin
        checkOutput("HEX3", 32'(hex3), 32'(expHex[0]));
        checkOutput("HEX2", 32'(hex2), 32'(expHex[1]));
        checkOutput("HEX1", 32'(hex1), 32'(expHex[2]));
        checkOutput("HEX0", 32'(hex0), 32'(expHex[3]));
        checkOutput("ptr", 32'(ptr), 32'(mPtr));
        checkOutput("full", 32'(full), 32'(mFull));
    end

    task automatic applyStimulus(input logic enterLvl, input logic clearLvl, input logic [3:0] swVal, input int cycles);
        keyEnter = enterLvl;
        keyClear = clearLvl;
        sw = swVal;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic pressEnter(input logic [3:0] v);
        applyStimulus(1'b0, 1'b1, v, DB + 2);
        applyStimulus(1'b1, 1'b1, v, DB + 4);
    endtask

    task automatic pressClear();
        applyStimulus(1'b1, 1'b0, sw, DB + 2);
        applyStimulus(1'b1, 1'b1, sw, DB + 4);
    endtask

    task automatic midCycleReset();
        #2 resetn = 1'b0;
        #1;
        checkOutput("async HEX3", 32'(hex3), 32'h7F);
        checkOutput("async HEX2", 32'(hex2), 32'h7F);
        checkOutput("async HEX1", 32'(hex1), 32'h7F);
        checkOutput("async HEX0", 32'(hex0), 32'h7F);
        checkOutput("async ptr", 32'(ptr), 32'd0);
        checkOutput("async full", 32'(full), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        resetn = 1'b0;
        keyEnter = 1'b1;
        keyClear = 1'b1;
        sw = 4'h0;
        repeat (3) @(negedge clock);
        checkOutput("reset HEX3", 32'(hex3), 32'h7F);
        checkOutput("reset ptr", 32'(ptr), 32'd0);
        checkOutput("reset full", 32'(full), 32'd0);

        resetn = 1'b1;
        @(negedge clock);
        checkOutput("cursor on", 32'(hex3), 32'(7'b1110111));
        repeat (8) @(negedge clock);
        checkOutput("cursor off", 32'(hex3), 32'h7F);
        checkOutput("blank HEX2", 32'(hex2), 32'h7F);

        pressEnter(4'hA);
        checkOutput("entry A", 32'(hex3), 32'(7'b0001000));
        checkOutput("entry ptr1", 32'(ptr), 32'd1);
        pressEnter(4'h3);
        checkOutput("entry 3", 32'(hex2), 32'(7'b0000110));
        checkOutput("entry ptr2", 32'(ptr), 32'd2);

        // Clear and enter land on the same cycle.
        applyStimulus(1'b0, 1'b0, 4'h9, DB + 2);
        applyStimulus(1'b1, 1'b1, 4'h9, DB + 4);
        checkOutput("clear prio ptr", 32'(ptr), 32'd0);
        checkOutput("clear prio HEX2", 32'(hex2), 32'h7F);
        checkOutput("clear prio HEX1", 32'(hex1), 32'h7F);

        for (int d = 1; d <= 4; d++) pressEnter(4'(d));
        pressEnter(4'hF);
        checkOutput("full HEX3", 32'(hex3), 32'(7'b1001111));
        checkOutput("full HEX2", 32'(hex2), 32'(7'b0010010));
        checkOutput("full HEX1", 32'(hex1), 32'(7'b0000110));
        checkOutput("full HEX0", 32'(hex0), 32'(7'b1001100));
        checkOutput("full flag", 32'(full), 32'd1);
        checkOutput("full ptr", 32'(ptr), 32'd3);

        midCycleReset();
        applyStimulus(1'b0, 1'b1, 4'h7, 2);
        resetn = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'h7, DB + 5);
        applyStimulus(1'b1, 1'b1, 4'h7, DB + 4);
        checkOutput("held key HEX3", 32'(hex3), 32'(7'b0001101));
        checkOutput("held key ptr", 32'(ptr), 32'd1);

        pressClear();
        applyStimulus(1'b0, 1'b1, 4'h5, 3);
        applyStimulus(1'b1, 1'b1, 4'h5, DB + 6);
        checkOutput("glitch ptr", 32'(ptr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h6, 2);
            applyStimulus(1'b1, 1'b1, 4'h6, 2);
        end
        applyStimulus(1'b0, 1'b1, 4'h6, DB + 3);
        applyStimulus(1'b1, 1'b1, 4'h6, DB + 4);
        checkOutput("bounce ptr", 32'(ptr), 32'd1);
        checkOutput("bounce HEX3", 32'(hex3), 32'(7'b0100000));

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    applyStimulus(1'b0, 1'b1, 4'($urandom), $urandom_range(DB, DB + 3));
                    applyStimulus(1'b1, 1'b1, sw, $urandom_range(DB + 2, DB + 5));
                end
                2: begin
                    applyStimulus(1'b1, 1'b0, 4'($urandom), $urandom_range(DB, DB + 3));
                    applyStimulus(1'b1, 1'b1, sw, $urandom_range(DB + 2, DB + 5));
                end
                3: begin
                    applyStimulus(1'b0, 1'b0, 4'($urandom), DB + 2);
                    applyStimulus(1'b1, 1'b1, sw, DB + 4);
                end
                4: begin
                    for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                        applyStimulus(1'b0, 1'b1, 4'($urandom), $urandom_range(1, DB - 1));
                        applyStimulus(1'b1, 1'b1, sw, $urandom_range(1, 3));
                    end
                    applyStimulus(1'($urandom), 1'b1, sw, DB + 2);
                    applyStimulus(1'b1, 1'b1, sw, DB + 4);
                end
                5: begin
                    for (int w = 0; w < 6; w++) applyStimulus(1'b1, 1'b1, 4'($urandom), 1);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        midCycleReset();
                        applyStimulus(1'($urandom), 1'b1, 4'($urandom), 2);
                        resetn = 1'b1;
                        applyStimulus(keyEnter, 1'b1, sw, DB + 4);
                        applyStimulus(1'b1, 1'b1, sw, DB + 4);
                    end else begin
                        applyStimulus(1'b1, 1'b1, sw, $urandom_range(1, 12));
                    end
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
